uart_transmitter: RTL and testbench

UART_TRANSMITTER -- requirements
Module: uart_transmitter

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_transmitter_baud_tick_gen.sv | 29 ++
 rtl/uart_transmitter.sv | 119 +++++++++++
 tb/tb_uart_transmitter.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants, line levels and the transmitter state type.
// The PARITY state only exists when UART_TX_PARITY_EN is defined.
package uart_pkg;

    localparam int UART_DATA_BITS            = 8;
    localparam int UART_DEFAULT_CLKS_PER_BIT = 16;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;
    localparam logic LINE_STOP  = 1'b1;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_t;
`endif

endpackage

// File: rtl/uart_transmitter_baud_tick_gen.sv
// Bit-period timer: down-counter reloaded on restart or terminal count,
// tick is high for the single cycle at each bit boundary.
module baud_tick_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (restart || count == '0) begin
            count <= RELOAD;
        end else begin
            count <= count - 1'b1;
        end
    end

    assign tick = !restart && (count == '0);

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: one-entry holding register feeding an 8N1 frame shifter
// (8E1 when UART_TX_PARITY_EN is defined).
//
//   state     | meaning
//   ST_IDLE   | line high; loads the frame from the holding register when full
//   ST_START  | start bit on the line
//   ST_DATA   | data bits, LSB first, indexed by bit_idx
//   ST_PARITY | even parity of the frame byte (parity builds only)
//   ST_STOP   | stop bit; chains straight into ST_START if a byte is pending
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [UART_DATA_BITS-1:0] din,
    input  logic                      din_valid,
    output logic                      din_ready,
    output logic                      tx,
    output logic                      busy
);

    tx_state_t                 state;
    logic [UART_DATA_BITS-1:0] hold_data;
    logic                      hold_full;
    logic [UART_DATA_BITS-1:0] frame_data;
    logic [2:0]                bit_idx;
    logic                      tick;
    logic                      restart;
    logic                      accept;

    assign accept  = din_valid && !hold_full;
    assign restart = (state == ST_IDLE);

    baud_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .reset  (reset),
        .restart(restart),
        .tick   (tick)
    );

    // tx is registered from the current state, so the line trails the state by one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            hold_data  <= '0;
            hold_full  <= 1'b0;
            frame_data <= '0;
            bit_idx    <= '0;
            tx         <= LINE_IDLE;
        end else begin
            if (accept) begin
                hold_data <= din;
                hold_full <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    tx <= LINE_IDLE;
                    if (hold_full) begin
                        frame_data <= hold_data;
                        hold_full  <= 1'b0;
                        state      <= ST_START;
                    end
                end
                ST_START: begin
                    tx <= LINE_START;
                    if (tick) begin
                        bit_idx <= '0;
                        state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    tx <= frame_data[bit_idx];
                    if (tick) begin
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_STOP;
`endif
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    tx <= ^frame_data;
                    if (tick) begin
                        state <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    tx <= LINE_STOP;
                    if (tick) begin
                        if (hold_full) begin
                            frame_data <= hold_data;
                            hold_full  <= 1'b0;
                            state      <= ST_START;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    tx    <= LINE_IDLE;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign din_ready = !hold_full;
    assign busy      = (state != ST_IDLE) || hold_full;

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter; frames are predicted from the line protocol
// (start, data LSB first, optional parity, stop) and compared cycle by cycle.
module tb_uart_transmitter;

    localparam int C = 16;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int MAXC = 20000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] din = 8'h00;
    logic       din_valid = 1'b0;
    logic       din_ready;
    logic       tx;
    logic       busy;

    uart_transmitter #(.CLKS_PER_BIT(C)) dut (
        .clk      (clk),
        .reset    (reset),
        .din      (din),
        .din_valid(din_valid),
        .din_ready(din_ready),
        .tx       (tx),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic tx_hist [MAXC];
    logic busy_hist [MAXC];
    logic rdy_hist [MAXC];
    logic exp_tx [MAXC];
    logic exp_busy [MAXC];
    logic exp_rdy [MAXC];

    always @(negedge clk) begin
        if (cyc < MAXC) begin
            tx_hist[cyc]   = tx;
            busy_hist[cyc] = busy;
            rdy_hist[cyc]  = din_ready;
        end
    end

    int checks = 0;
    int failures = 0;
    int fr_hs[$];
    logic [7:0] fr_dat[$];
    string sig_name [3] = '{"tx", "busy", "din_ready"};

    initial begin
        #300000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    function automatic logic frame_bit(logic [7:0] b, int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
        if (k == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // Frames start two edges after their handshake, or right after the previous frame.
    function automatic void build_model(int t0, int t1);
        int prev_end, s, e;
        for (int c = t0; c < t1 && c < MAXC; c++) begin
            exp_tx[c] = 1'b1; exp_busy[c] = 1'b0; exp_rdy[c] = 1'b1;
        end
        prev_end = 0;
        foreach (fr_hs[i]) begin
            s = (fr_hs[i] + 2 > prev_end) ? fr_hs[i] + 2 : prev_end;
            e = s + FB * C;
            for (int c = s; c < e && c < MAXC; c++) exp_tx[c] = frame_bit(fr_dat[i], (c - s) / C);
            for (int c = fr_hs[i]; c < e - 1 && c < MAXC; c++) exp_busy[c] = 1'b1;
            for (int c = fr_hs[i]; c < s - 1 && c < MAXC; c++) exp_rdy[c] = 1'b0;
            prev_end = e;
        end
    endfunction

    function automatic int first_diff(input int t0, input int t1, input int sel,
                                      output logic got, output logic want);
        got = 1'b0; want = 1'b0;
        for (int c = t0; c < t1 && c < MAXC; c++) begin
            case (sel)
                0: begin got = tx_hist[c];   want = exp_tx[c];   end
                1: begin got = busy_hist[c]; want = exp_busy[c]; end
                default: begin got = rdy_hist[c]; want = exp_rdy[c]; end
            endcase
            if (got !== want) return c;
        end
        return -1;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            din = 8'($urandom);
            @(negedge clk);
        end
    endtask

    task automatic offer(input logic [7:0] b, output int hs);
        int waited;
        waited = 0;
        hs = -1;
        din = b;
        din_valid = 1'b1;
        while (din_ready !== 1'b1 && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 2000) begin
            checks++; failures++;
            $display("FAIL offer_timeout byte=%02h din_ready=%b want=1", b, din_ready);
            din_valid = 1'b0;
            return;
        end
        hs = cyc + 1;
        fr_hs.push_back(hs);
        fr_dat.push_back(b);
        @(negedge clk);
        din_valid = 1'b0;
        din = 8'($urandom);
    endtask

    task automatic wait_done();
        int waited;
        waited = 0;
        while (busy !== 1'b0 && waited < 5000) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL busy_settle busy=%b want=0", busy);
        end
        idle(4);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b exp=1", tx); end
        checks++; if (din_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", din_ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        reset = 1'b0;
        idle(2);
    endtask

    task automatic test_single();
        int t0, hs, s, d, bad;
        logic g, w;
`ifdef UART_TX_PARITY_EN
        logic pat [FB] = '{0, 1, 1, 1, 0, 1, 1, 1, 0, 0, 1};
`else
        logic pat [FB] = '{0, 1, 1, 1, 0, 1, 1, 1, 0, 1};
`endif
        fr_hs.delete(); fr_dat.delete();
        t0 = cyc + 1;
        offer(8'h77, hs);
        wait_done();
        s = hs + 2;
        checks++;
        if (tx_hist[s-1] !== 1'b1) begin failures++; $display("FAIL single_prestart tx=%b exp=1", tx_hist[s-1]); end
        bad = -1;
        for (int k = 0; k < FB; k++)
            for (int j = 0; j < C; j++)
                if (bad < 0 && tx_hist[s + k*C + j] !== pat[k]) bad = k*C + j;
        checks++;
        if (bad >= 0) begin
            failures++;
            $display("FAIL single_0x77 offset=%0d tx=%b exp=%b", bad, tx_hist[s+bad], pat[bad/C]);
        end
        checks++;
        if (busy_hist[s + FB*C] !== 1'b0 || tx_hist[s + FB*C] !== 1'b1)
            begin failures++; $display("FAIL single_after busy=%b tx=%b exp busy=0 tx=1", busy_hist[s+FB*C], tx_hist[s+FB*C]); end
        build_model(t0, cyc);
        for (int k = 0; k < 3; k++) begin
            d = first_diff(t0, cyc, k, g, w);
            checks++;
            if (d >= 0) begin failures++; $display("FAIL single_trace %s cyc=%0d got=%b exp=%b", sig_name[k], d, g, w); end
        end
    endtask

    task automatic test_back_to_back();
        int t0, hs1, hs2, s1, d;
        logic g, w;
        fr_hs.delete(); fr_dat.delete();
        t0 = cyc + 1;
        offer(8'h61, hs1);
        offer(8'h64, hs2);
        wait_done();
        s1 = hs1 + 2;
        checks++;
        if (tx_hist[s1 + FB*C - 1] !== 1'b1 || tx_hist[s1 + FB*C] !== 1'b0)
            begin failures++; $display("FAIL b2b_seam stop=%b start=%b exp 1 then 0", tx_hist[s1+FB*C-1], tx_hist[s1+FB*C]); end
        checks++;
        if (tx_hist[s1 + 2*FB*C] !== 1'b1 || busy_hist[s1 + 2*FB*C] !== 1'b0)
            begin failures++; $display("FAIL b2b_end tx=%b busy=%b exp tx=1 busy=0", tx_hist[s1+2*FB*C], busy_hist[s1+2*FB*C]); end
        build_model(t0, cyc);
        for (int k = 0; k < 3; k++) begin
            d = first_diff(t0, cyc, k, g, w);
            checks++;
            if (d >= 0) begin failures++; $display("FAIL b2b_trace %s cyc=%0d got=%b exp=%b", sig_name[k], d, g, w); end
        end
    endtask

    task automatic test_stall();
        int t0, hs1, hs2, hs3, d;
        logic g, w;
        fr_hs.delete(); fr_dat.delete();
        t0 = cyc + 1;
        offer(8'h41, hs1);
        offer(8'h42, hs2);
        offer(8'h43, hs3);
        wait_done();
        checks++;
        if (hs2 != hs1 + 2) begin failures++; $display("FAIL stall_hs2 got=%0d exp=%0d", hs2, hs1 + 2); end
        checks++;
        if (hs3 != hs1 + 2 + FB*C) begin failures++; $display("FAIL stall_hs3 got=%0d exp=%0d", hs3, hs1 + 2 + FB*C); end
        build_model(t0, cyc);
        for (int k = 0; k < 3; k++) begin
            d = first_diff(t0, cyc, k, g, w);
            checks++;
            if (d >= 0) begin failures++; $display("FAIL stall_trace %s cyc=%0d got=%b exp=%b", sig_name[k], d, g, w); end
        end
    endtask

    task automatic test_reset_mid_frame();
        int hs1, hs2, s, t0, d;
        logic g, w;
        fr_hs.delete(); fr_dat.delete();
        offer(8'hA5, hs1);
        offer(8'h5A, hs2);
        s = hs1 + 2;
        idle(s + 4*C + 5 - cyc);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (tx_hist[cyc-1] !== 1'b0) begin failures++; $display("FAIL rst_prebit3 tx=%b exp=0", tx_hist[cyc-1]); end
        checks++;
        if (tx !== 1'b1 || din_ready !== 1'b1 || busy !== 1'b0)
            begin failures++; $display("FAIL rst_mid tx=%b ready=%b busy=%b exp 1 1 0", tx, din_ready, busy); end
        t0 = cyc;
        idle(400);
        fr_hs.delete(); fr_dat.delete();
        build_model(t0, cyc);
        for (int k = 0; k < 2; k++) begin
            d = first_diff(t0, cyc, k, g, w);
            checks++;
            if (d >= 0) begin failures++; $display("FAIL rst_quiet %s cyc=%0d got=%b exp=%b", sig_name[k], d, g, w); end
        end
        reset = 1'b1; din = 8'h3C; din_valid = 1'b1;
        @(negedge clk);
        reset = 1'b0; din_valid = 1'b0;
        t0 = cyc;
        idle(60);
        checks++;
        if (busy !== 1'b0 || din_ready !== 1'b1)
            begin failures++; $display("FAIL rst_priority busy=%b ready=%b exp 0 1", busy, din_ready); end
        build_model(t0, cyc);
        d = first_diff(t0, cyc, 0, g, w);
        checks++;
        if (d >= 0) begin failures++; $display("FAIL rst_priority_tx cyc=%0d got=%b exp=%b", d, g, w); end
    endtask

    task automatic test_idle_toggle();
        int t0, d;
        logic g, w;
        fr_hs.delete(); fr_dat.delete();
        t0 = cyc + 1;
        idle(500);
        build_model(t0, cyc);
        for (int k = 0; k < 3; k++) begin
            d = first_diff(t0, cyc, k, g, w);
            checks++;
            if (d >= 0) begin failures++; $display("FAIL idle_trace %s cyc=%0d got=%b exp=%b", sig_name[k], d, g, w); end
        end
    endtask

    task automatic test_random(input int n);
        int t0, hs, d;
        logic g, w;
        fr_hs.delete(); fr_dat.delete();
        t0 = cyc + 1;
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 3))
                1: idle($urandom_range(1, 20));
                2: idle($urandom_range(100, 200));
                default: ;
            endcase
            offer(8'($urandom), hs);
        end
        wait_done();
        build_model(t0, cyc);
        for (int k = 0; k < 3; k++) begin
            d = first_diff(t0, cyc, k, g, w);
            checks++;
            if (d >= 0) begin failures++; $display("FAIL random_trace %s cyc=%0d got=%b exp=%b", sig_name[k], d, g, w); end
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        int hs;
        fr_hs.delete(); fr_dat.delete();
        offer(8'h73, hs);
        wait_done();
        checks++;
        if (tx_hist[hs + 2 + 9*C + C/2] !== 1'b1) begin failures++; $display("FAIL parity_0x73 got=%b exp=1", tx_hist[hs+2+9*C+C/2]); end
        checks++;
        if (busy_hist[hs + 2 + 176 - 2] !== 1'b1 || busy_hist[hs + 2 + 176] !== 1'b0)
            begin failures++; $display("FAIL parity_len busy_end=%b after=%b exp 1 0", busy_hist[hs+176], busy_hist[hs+178]); end
        offer(8'h77, hs);
        wait_done();
        checks++;
        if (tx_hist[hs + 2 + 9*C + C/2] !== 1'b0) begin failures++; $display("FAIL parity_0x77 got=%b exp=0", tx_hist[hs+2+9*C+C/2]); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_reset_mid_frame();
        test_idle_toggle();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        test_random(12);
        test_random(12);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
